ssd_scan_ctrl: RTL

- Time-multiplexed scan controller for the 4-digit common-anode seven-segment display on the lab board.
- Holds four BCD digits plus decimal points in a shadow register. Copies them into a frame register only at frame boundaries, so a display update never tears mid-frame.
- Drives one digit at a time. Inserts all-off guard cycles between digits against ghosting.
- Decodes BCD to the active-low segment pattern on D_ssd.

---
 rtl/ssd_scan_ctrl.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ssd_scan_ctrl.sv
// rtl/ssd_scan_ctrl.sv - Four-digit seven-segment scan controller with tear-free frame update
module ssd_scan_ctrl #(
    parameter int DIGIT_PERIOD = 100000,
    parameter int GUARD_CYCLES = 8,
    parameter int CNT_W        = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        load,
    input  logic [15:0] bcd_in,
    input  logic [3:0]  dp_in,
    input  logic        lz_en,
    output logic [7:0]  D_ssd,
    output logic [3:0]  d,
    output logic        frame_sync
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHOW  = 2'd1;
    localparam logic [1:0] S_GUARD = 2'd2;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIGIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam bit               NO_GUARD   = (GUARD_CYCLES == 0);

    // Packed as {dp[3:0], d3, d2, d1, d0}
    logic [19:0]      shadow_q, shadow_d;
    logic [19:0]      frame_q, frame_d;
    logic [1:0]       state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       dig_q, dig_d;
    logic [7:0]       seg_q, seg_d;
    logic             sync_q, sync_d;

    // Active-low a..g pattern for one BCD digit; non-decimal codes show a dash
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111110;
        endcase
        return s;
    endfunction

    // Scan sequencing: shadow capture, frame reload at boundaries, digit/guard timing
    always_comb begin
        logic adv;
        adv      = 1'b0;
        shadow_d = load ? {dp_in, bcd_in} : shadow_q;
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        frame_d  = frame_q;
        sync_d   = 1'b0;
        if (!en) begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    frame_d = shadow_q;
                    sync_d  = 1'b1;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    state_d = S_SHOW;
                end
                S_SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        cnt_d = '0;
                        if (NO_GUARD) begin
                            adv = 1'b1;
                        end else begin
                            state_d = S_GUARD;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_GUARD: begin
                    if (cnt_q == GUARD_LAST) begin
                        cnt_d = '0;
                        adv   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                end
            endcase
            // Old shadow goes into the frame, so a load on this same edge lands next frame
            if (adv) begin
                idx_d   = idx_q + 2'd1;
                state_d = S_SHOW;
                if (idx_q == 2'd3) begin
                    frame_d = shadow_q;
                    sync_d  = 1'b1;
                end
            end
        end
    end

    // Output pattern for the state about to be held, so registered outputs line up with it
    always_comb begin
        logic [3:0] nib;
        logic       dp;
        logic       z3;
        logic       z2;
        logic       z1;
        logic       blank;
        nib   = frame_d[idx_d*4 +: 4];
        dp    = frame_d[16 + idx_d];
        z3    = (frame_d[15:12] == 4'd0);
        z2    = (frame_d[11:8] == 4'd0);
        z1    = (frame_d[7:4] == 4'd0);
        blank = lz_en && (((idx_d == 2'd3) && z3) ||
                          ((idx_d == 2'd2) && z3 && z2) ||
                          ((idx_d == 2'd1) && z3 && z2 && z1));
        dig_d = 4'b1111;
        seg_d = 8'hFF;
        if (state_d == S_SHOW) begin
            dig_d = ~(4'b0001 << idx_d);
            seg_d = {(blank ? 7'b1111111 : decode(nib)), ~dp};
        end
    end

    // State and output registers; reset blanks the display without waiting for a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            frame_q  <= '0;
            state_q  <= S_IDLE;
            idx_q    <= 2'd0;
            cnt_q    <= '0;
            dig_q    <= 4'b1111;
            seg_q    <= 8'hFF;
            sync_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            dig_q    <= dig_d;
            seg_q    <= seg_d;
            sync_q   <= sync_d;
        end
    end

    assign d          = dig_q;
    assign D_ssd      = seg_q;
    assign frame_sync = sync_q;

endmodule
